// File: rtl/inv_range_norm.sv
// Range-reduction wrapper around the Newton-Raphson reciprocal unit INV: normalises a positive
// Q8.24 divisor into [0.5, 1), runs INV through its start/done handshake, then rescales with saturation.
module inv_range_norm #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAC_BITS = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              out_sat,
    output logic              inv_start,
    output logic [DATA_W-1:0] inv_dd,
    input  logic [DATA_W-1:0] inv_q,
    input  logic              inv_done
);

    localparam int unsigned       SHW     = $clog2(DATA_W);
    localparam logic [SHW-1:0]    FB_M1   = SHW'(FRAC_BITS - 1);
    localparam logic [DATA_W-1:0] SAT_VAL = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, NORM, ISSUE, DRAIN, DENORM, OUT} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] d_q;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] m_q;
    logic [DATA_W-1:0] out_data_q;
    logic [SHW-1:0]    amt_q;
    logic              shr_q;
    logic              inv_start_q;
    logic              out_valid_q;
    logic              out_err_q;
    logic              out_sat_q;

    logic [SHW-1:0]      msb_d;
    logic [SHW-1:0]      amt_d;
    logic                shr_d;
    logic [DATA_W-1:0]   m_d;
    logic [2*DATA_W-1:0] y_d;
    logic                y_ovf_d;
    logic                nonpos_d;

    // Signed shift s = msb - (FRAC_BITS-1) is kept as direction (shr) plus magnitude (amt).
    always_comb begin
        msb_d = '0;
        for (int unsigned i = 0; i < DATA_W - 1; i++) begin
            if (d_q[i]) msb_d = SHW'(i);
        end
        shr_d = (msb_d >= FB_M1);
        amt_d = shr_d ? (msb_d - FB_M1) : (FB_M1 - msb_d);
        m_d   = shr_d ? (d_q >> amt_d) : (d_q << amt_d);
    end

    always_comb begin
        y_d     = shr_q ? ({{DATA_W{1'b0}}, r_q} >> amt_q)
                        : ({{DATA_W{1'b0}}, r_q} << amt_q);
        y_ovf_d = |y_d[2*DATA_W-1:DATA_W-1];
    end

    assign nonpos_d = in_data[DATA_W-1] || (in_data == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            d_q         <= '0;
            r_q         <= '0;
            m_q         <= '0;
            amt_q       <= '0;
            shr_q       <= 1'b0;
            inv_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        d_q <= in_data;
                        if (nonpos_d) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= SAT_VAL;
                            out_err_q   <= 1'b1;
                            out_sat_q   <= 1'b0;
                            state_q     <= OUT;
                        end else begin
                            state_q <= NORM;
                        end
                    end
                end
                NORM: begin
                    m_q         <= m_d;
                    amt_q       <= amt_d;
                    shr_q       <= shr_d;
                    inv_start_q <= 1'b1;
                    state_q     <= ISSUE;
                end
                ISSUE: begin
                    if (inv_done) begin
                        r_q         <= inv_q;
                        inv_start_q <= 1'b0;
                        state_q     <= DRAIN;
                    end
                end
                // INV must fall back to idle before another start can be issued.
                DRAIN: begin
                    if (!inv_done) state_q <= DENORM;
                end
                DENORM: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= y_ovf_d ? SAT_VAL : y_d[DATA_W-1:0];
                    out_sat_q   <= y_ovf_d;
                    out_err_q   <= 1'b0;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign out_sat   = out_sat_q;
    assign inv_start = inv_start_q;
    assign inv_dd    = m_q;

endmodule

// File: tb/tb_inv_range_norm.sv
// Directed bench for inv_range_norm with a behavioural INV stand-in returning floor(2^48/dd).
module tb_inv_range_norm;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic        out_sat;
    logic        inv_start;
    logic [31:0] inv_dd;
    logic [31:0] inv_q;
    logic        inv_done;

    int checks = 0;
    int errors = 0;

    inv_range_norm #(
        .DATA_W    (32),
        .FRAC_BITS (24)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_sat   (out_sat),
        .inv_start (inv_start),
        .inv_dd    (inv_dd),
        .inv_q     (inv_q),
        .inv_done  (inv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // INV stand-in: 5 cycles after start it raises done for 3 cycles with the exact reciprocal.
    int unsigned lat_cnt;
    logic        done_m;
    logic [31:0] q_m;
    logic        spur;
    logic [31:0] spur_q;
    int          start_cnt = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_cnt <= 0;
            done_m  <= 1'b0;
            q_m     <= '0;
        end else if (lat_cnt == 0) begin
            if (inv_start) lat_cnt <= 1;
        end else begin
            lat_cnt <= lat_cnt + 1;
            if (lat_cnt == 5) begin
                done_m <= 1'b1;
                q_m    <= (inv_dd == 0) ? 32'hFFFF_FFFF : 32'((64'd1 << 48) / {32'd0, inv_dd});
            end
            if (lat_cnt == 8) begin
                done_m  <= 1'b0;
                lat_cnt <= 0;
            end
        end
    end

    always @(posedge clk) begin
        if (inv_start) start_cnt <= start_cnt + 1;
    end

    assign inv_done = done_m | spur;
    assign inv_q    = spur ? spur_q : q_m;

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_norm(input logic [31:0] d, input logic [31:0] exp_dd,
                            input logic [31:0] exp_out, input logic exp_sat,
                            input int bp, input logic keep, input logic [31:0] nd,
                            input string tag);
        int n;
        chk(in_ready, 1, {tag, ":idle_rdy"});
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        if (keep) in_data = nd;
        else in_valid = 1'b0;
        chk(in_ready, 0, {tag, ":norm_rdy"});
        chk(inv_start, 0, {tag, ":norm_start"});
        @(negedge clk);
        chk(inv_start, 1, {tag, ":start"});
        chk(inv_dd, exp_dd, {tag, ":dd"});
        n = 0;
        while (!inv_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(inv_done, 1, {tag, ":done_timeout"});
        chk(inv_start, 1, {tag, ":start_hold"});
        @(negedge clk);
        chk(inv_start, 0, {tag, ":start_drop"});
        n = 0;
        while (inv_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(inv_done, 0, {tag, ":drain_timeout"});
        @(negedge clk);
        chk(out_valid, 0, {tag, ":denorm"});
        @(negedge clk);
        chk(out_valid, 1, {tag, ":ovalid"});
        chk(out_data, exp_out, {tag, ":data"});
        chk(out_err, 0, {tag, ":err"});
        chk(out_sat, exp_sat, {tag, ":sat"});
        chk(in_ready, 0, {tag, ":out_rdy"});
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk({out_valid, out_err, out_sat, out_data}, {1'b1, 1'b0, exp_sat, exp_out},
                {tag, ":bp_hold"});
            chk(in_ready, 0, {tag, ":bp_rdy"});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk(out_valid, 0, {tag, ":released"});
        chk(in_ready, 1, {tag, ":back_idle"});
    endtask

    task automatic run_err(input logic [31:0] d, input string tag);
        int snap;
        snap     = start_cnt;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        chk(out_valid, 1, {tag, ":ovalid"});
        chk(out_data, 32'h7FFF_FFFF, {tag, ":data"});
        chk(out_err, 1, {tag, ":err"});
        chk(out_sat, 0, {tag, ":sat"});
        chk(in_ready, 0, {tag, ":rdy"});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk(out_valid, 0, {tag, ":released"});
        chk(in_ready, 1, {tag, ":back_idle"});
        chk(start_cnt - snap, 0, {tag, ":no_start"});
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        spur      = 1'b0;
        spur_q    = '0;
        repeat (2) @(negedge clk);
        chk({out_valid, out_err, out_sat, inv_start}, 0, "rst_flags");
        chk(out_data, 0, "rst_data");
        chk(inv_dd, 0, "rst_dd");
        chk(in_ready, 1, "rst_rdy");
        rstn = 1'b1;
        @(negedge clk);

        run_norm(32'h0100_0000, 32'h0080_0000, 32'h0100_0000, 1'b0, 10, 1'b0, '0, "one");
        run_norm(32'h0400_0000, 32'h0080_0000, 32'h0040_0000, 1'b0, 0, 1'b1, 32'h0040_0000, "four");
        run_norm(32'h0040_0000, 32'h0080_0000, 32'h0400_0000, 1'b0, 0, 1'b0, '0, "quarter");
        run_norm(32'h0300_0000, 32'h00C0_0000, 32'h0055_5555, 1'b0, 0, 1'b0, '0, "three");
        run_norm(32'h7FFF_FFFF, 32'h00FF_FFFF, 32'h0002_0000, 1'b0, 0, 1'b0, '0, "max");
        run_norm(32'h0000_0001, 32'h0080_0000, 32'h7FFF_FFFF, 1'b1, 0, 1'b0, '0, "lsb_sat");
        run_norm(32'h0002_0000, 32'h0080_0000, 32'h7FFF_FFFF, 1'b1, 0, 1'b0, '0, "r128_sat");

        run_err(32'h0000_0000, "zero");
        run_err(32'hFF00_0000, "neg_one");

        spur   = 1'b1;
        spur_q = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        spur = 1'b0;
        chk({out_valid, inv_start}, 0, "spur_quiet");
        chk(in_ready, 1, "spur_rdy");

        in_valid = 1'b1;
        in_data  = 32'h0200_0000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk(inv_start, 1, "mid_issue");
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk({out_valid, out_err, out_sat, inv_start}, 0, "midrst_flags");
        chk(out_data, 0, "midrst_data");
        chk(inv_dd, 0, "midrst_dd");
        chk(in_ready, 1, "midrst_rdy");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_norm(32'h0200_0000, 32'h0080_0000, 32'h0080_0000, 1'b0, 0, 1'b0, '0, "two");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
